// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, ID/EX control bundle and bubble constant for the five-stage core
package pipe_pkg;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_ALUOP_W = 4;
    localparam int REG_W       = 5;

    typedef struct packed {
        logic                   regwrite;
        logic                   memread;
        logic                   memwrite;
        logic                   memtoreg;
        logic                   alusrc;
        logic                   branch;
        logic [DEF_ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare and IF/ID stall request
//   ex_valid_i, ex_memread_i, ex_rd_i : instruction currently in EX
//   id_valid_i, id_rs1_i, id_rs2_i    : instruction currently in ID
//   hold_i, flush_i                   : downstream stall, branch squash
//   lu_o                              : load in EX feeds ID instruction
//   stall_if_o                        : freeze PC and IF/ID this cycle
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             hold_i,
    input  logic             flush_i,
    output logic             lu_o,
    output logic             stall_if_o
);
    // x0 is never a real producer, so a load to x0 cannot create a hazard
    assign lu_o = ex_valid_i & ex_memread_i & (ex_rd_i != '0) & id_valid_i &
                  ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    // a flushed ID instruction is discarded, so there is nothing to re-present
    assign stall_if_o = hold_i | (lu_o & ~flush_i);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use interlock, hold and flush
//   clk, rst (async, active-high), hold, flush
//   id_*            : decoded instruction from ID
//   regwrite_wb, wr_wb, wb_data : WB write port, used only with RF_BYPASS_EN
//   ex_*, regrs*_ex, wr_ex, *_ex : registered EX-side copies
//   stall_if        : freeze PC and IF/ID register this cycle
// Build option: define RF_BYPASS_EN to forward a same-cycle WB write into the captured operands.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int ALUOP_W = DEF_ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic [REG_W-1:0]   id_rd,
    input  logic [XLEN-1:0]    id_rdata1,
    input  logic [XLEN-1:0]    id_rdata2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_alusrc,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               regwrite_wb,
    input  logic [REG_W-1:0]   wr_wb,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rdata1,
    output logic [XLEN-1:0]    ex_rdata2,
    output logic [XLEN-1:0]    ex_imm,
    output logic [REG_W-1:0]   regrs1_ex,
    output logic [REG_W-1:0]   regrs2_ex,
    output logic [REG_W-1:0]   wr_ex,
    output logic               regwrite_ex,
    output logic               memread_ex,
    output logic               memwrite_ex,
    output logic               memtoreg_ex,
    output logic               alusrc_ex,
    output logic               branch_ex,
    output logic [ALUOP_W-1:0] aluop_ex,
    output logic               stall_if
);
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [REG_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             lu, bubble;

    hazard_detect u_hazard (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .hold_i       (hold),
        .flush_i      (flush),
        .lu_o         (lu),
        .stall_if_o   (stall_if)
    );

`ifdef RF_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = regwrite_wb & (wr_wb != '0) & (wr_wb == id_rs1);
    assign byp2 = regwrite_wb & (wr_wb != '0) & (wr_wb == id_rs2);
`else
    logic unused_wb;
    assign unused_wb = ^{regwrite_wb, wr_wb, wb_data};
`endif

    // the interlock needs no state: the bubble clears memread_ex, so lu drops next cycle
    always_comb begin
        bubble   = flush | lu;
        valid_d  = ~bubble & id_valid;
        ctrl_d   = (bubble | ~id_valid) ? CTRL_BUBBLE :
                   ctrl_t'{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                           memtoreg: id_memtoreg, alusrc: id_alusrc, branch: id_branch,
                           aluop: id_aluop};
        pc_d     = bubble ? '0 : id_pc;
        imm_d    = bubble ? '0 : id_imm;
        rs1_d    = bubble ? '0 : id_rs1;
        rs2_d    = bubble ? '0 : id_rs2;
        rd_d     = bubble ? '0 : id_rd;
`ifdef RF_BYPASS_EN
        rdata1_d = bubble ? '0 : byp1 ? wb_data : id_rdata1;
        rdata2_d = bubble ? '0 : byp2 ? wb_data : id_rdata2;
`else
        rdata1_d = bubble ? '0 : id_rdata1;
        rdata2_d = bubble ? '0 : id_rdata2;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            ctrl_q   <= CTRL_BUBBLE;
        end else if (!hold) begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rdata1   = rdata1_q;
    assign ex_rdata2   = rdata2_q;
    assign ex_imm      = imm_q;
    assign regrs1_ex   = rs1_q;
    assign regrs2_ex   = rs2_q;
    assign wr_ex       = rd_q;
    assign regwrite_ex = ctrl_q.regwrite;
    assign memread_ex  = ctrl_q.memread;
    assign memwrite_ex = ctrl_q.memwrite;
    assign memtoreg_ex = ctrl_q.memtoreg;
    assign alusrc_ex   = ctrl_q.alusrc;
    assign branch_ex   = ctrl_q.branch;
    assign aluop_ex    = ctrl_q.aluop;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    logic clk = 1'b0, rst = 1'b1, hold = 1'b0, flush = 1'b0;
    logic id_valid = 1'b0;
    logic [31:0] id_pc = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic id_regwrite = 1'b0, id_memread = 1'b0, id_memwrite = 1'b0;
    logic id_memtoreg = 1'b0, id_alusrc = 1'b0, id_branch = 1'b0;
    logic [3:0] id_aluop = '0;
    logic regwrite_wb = 1'b0;
    logic [4:0] wr_wb = '0;
    logic [31:0] wb_data = '0;
    logic ex_valid;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0] regrs1_ex, regrs2_ex, wr_ex;
    logic regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex, branch_ex;
    logic [3:0] aluop_ex;
    logic stall_if;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch),
        .id_aluop(id_aluop), .regwrite_wb(regwrite_wb), .wr_wb(wr_wb), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .regrs1_ex(regrs1_ex), .regrs2_ex(regrs2_ex), .wr_ex(wr_ex),
        .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
        .memtoreg_ex(memtoreg_ex), .alusrc_ex(alusrc_ex), .branch_ex(branch_ex),
        .aluop_ex(aluop_ex), .stall_if(stall_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  c;
        logic [3:0]  op;
    } ex_t;

    ex_t m = '0;
    ex_t sb[$];
    int checks = 0, errors = 0;

    // control field order: regwrite, memread, memwrite, memtoreg, alusrc, branch
    localparam logic [5:0] C_LW  = 6'b110110;
    localparam logic [5:0] C_ADD = 6'b100000;

    function automatic ex_t actual();
        actual = {ex_valid, ex_pc, ex_rdata1, ex_rdata2, ex_imm, regrs1_ex, regrs2_ex, wr_ex,
                  regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex, branch_ex, aluop_ex};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // drive ID for the coming edge, check stall_if, and push the expected EX state
    task automatic apply(input string nm, input logic v, input logic [4:0] rs1, rs2, rd,
                         input logic [31:0] pc, d1, d2, imm, input logic [5:0] c,
                         input logic [3:0] op, input logic es, input logic h = 0,
                         input logic f = 0, input logic rw = 0, input logic [4:0] wa = 0,
                         input logic [31:0] wd = 0);
        ex_t n;
        logic lu;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = pc; id_rdata1 = d1; id_rdata2 = d2; id_imm = imm;
        {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch} = c;
        id_aluop = op; hold = h; flush = f;
        regwrite_wb = rw; wr_wb = wa; wb_data = wd;
        #1 chk({nm, " stall_if"}, stall_if, es);
        lu = m.v & m.c[4] & (m.rd != 0) & v & ((m.rd == rs1) | (m.rd == rs2));
        if (h) n = m;
        else if (f | lu) n = '0;
        else begin
            n.v = v; n.pc = pc; n.imm = imm; n.rs1 = rs1; n.rs2 = rs2; n.rd = rd;
            n.c = v ? c : 6'b0;
            n.op = v ? op : 4'b0;
`ifdef RF_BYPASS_EN
            n.d1 = (rw && wa != 0 && wa == rs1) ? wd : d1;
            n.d2 = (rw && wa != 0 && wa == rs2) ? wd : d2;
`else
            n.d1 = d1;
            n.d2 = d2;
`endif
        end
        m = n;
        sb.push_back(n);
    endtask

    task automatic issue(input string nm, input logic v, input logic [4:0] rs1, rs2, rd,
                         input logic [31:0] pc, d1, d2, imm, input logic [5:0] c,
                         input logic [3:0] op, input logic es, input logic h = 0,
                         input logic f = 0, input logic rw = 0, input logic [4:0] wa = 0,
                         input logic [31:0] wd = 0);
        @(negedge clk);
        apply(nm, v, rs1, rs2, rd, pc, d1, d2, imm, c, op, es, h, f, rw, wa, wd);
    endtask

    // monitor: every edge that has an expectation pending is compared
    initial forever begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) chk("ex_state", actual(), sb.pop_front());
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset ex_state", actual(), '0);
        chk("reset stall_if", stall_if, 1'b0);
        rst = 1'b0;
        issue("n0", 1, 1, 2, 3, 32'h100, 32'h11, 32'h12, 32'h4, C_ADD, 4'h2, 0);
        issue("n1", 1, 4, 5, 6, 32'h104, 32'h21, 32'h22, 32'h8, C_ADD, 4'h3, 0);
        issue("n2", 1, 7, 8, 9, 32'h108, 32'h31, 32'h32, 32'hc, 6'b001011, 4'h1, 0);
        issue("n3", 1, 10, 11, 12, 32'h10c, 32'h41, 32'h42, 32'h10, C_ADD, 4'h7, 0);
        issue("lw5", 1, 1, 0, 5, 32'h200, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        issue("lu", 1, 5, 7, 6, 32'h204, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 1);
        issue("lu_re", 1, 5, 7, 6, 32'h204, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 0);
        issue("lw0", 1, 1, 0, 0, 32'h300, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        issue("x0rd", 1, 0, 0, 8, 32'h304, 32'h0, 32'h0, 32'h0, C_ADD, 4'h2, 0);
        issue("lw5b", 1, 1, 0, 5, 32'h400, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        issue("lu_flush", 1, 7, 5, 6, 32'h404, 32'h77, 32'h55, 32'h0, C_ADD, 4'h2, 0, 0, 1);
        issue("lw5c", 1, 1, 0, 5, 32'h500, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        issue("lu_hold0", 1, 5, 7, 6, 32'h504, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 1, 1);
        issue("lu_hold1", 1, 5, 7, 6, 32'h504, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 1, 1);
        issue("lu_unhold", 1, 5, 7, 6, 32'h504, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 1);
        issue("lu_unhold_re", 1, 5, 7, 6, 32'h504, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 0);
        issue("bb_lw5", 1, 1, 0, 5, 32'h600, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        issue("bb_lw6", 1, 5, 0, 6, 32'h604, 32'h55, 32'h0, 32'h8, C_LW, 4'h0, 1);
        issue("bb_lw6_re", 1, 5, 0, 6, 32'h604, 32'h55, 32'h0, 32'h8, C_LW, 4'h0, 0);
        issue("bb_add", 1, 9, 6, 7, 32'h608, 32'h99, 32'h66, 32'h0, C_ADD, 4'h2, 1);
        issue("bb_add_re", 1, 9, 6, 7, 32'h608, 32'h99, 32'h66, 32'h0, C_ADD, 4'h2, 0);
        issue("inval", 0, 6, 6, 6, 32'h700, 32'h1, 32'h2, 32'h3, 6'b111111, 4'hf, 0);
        issue("byp", 1, 4, 3, 9, 32'h800, 32'h4, 32'h1, 32'h0, C_ADD, 4'h2, 0, 0, 0,
              1, 3, 32'hdeadbeef);
        issue("byp_x0", 1, 0, 2, 9, 32'h804, 32'h5, 32'h6, 32'h0, C_ADD, 4'h2, 0, 0, 0,
              1, 0, 32'hcafef00d);
        issue("rst_lw5", 1, 1, 0, 5, 32'h900, 32'h50, 32'h0, 32'h4, C_LW, 4'h0, 0);
        @(negedge clk);
        id_valid = 1; id_rs1 = 5; id_rs2 = 7; id_rd = 6; id_memread = 0;
        #1 chk("rst_pre stall_if", stall_if, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst_async ex_state", actual(), '0);
        chk("rst_async stall_if", stall_if, 1'b0);
        m = '0;
        @(negedge clk);
        rst = 1'b0;
        apply("rst_release", 1, 5, 7, 6, 32'h904, 32'h55, 32'h77, 32'h0, C_ADD, 4'h2, 0);
        issue("tail", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 6'b0, 4'h0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
